// File: rtl/debouncer.sv
// Per-channel switch debouncer: a new level is accepted only after STABLE_CYCLES consecutive differing samples.
// Optional edge outputs (rise/fall/changed) are built only when DEBOUNCER_EDGE_PULSE_EN is defined.
module debouncer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      out_q <= {WIDTH{RESET_LEVEL}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_STABLE: begin
          if (in[i] != out_q[i]) begin
            state_d[i] = ST_CHECK;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_CHECK: begin
          // Any sample matching the current level rejects the pending change.
          if (in[i] == out_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
            out_d[i]   = in[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign out = out_q;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             changed_q;

  // Pulses are registered from the same next-state as out, so they line up with the out update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= out_d & ~out_q;
      fall_q    <= ~out_d & out_q;
      changed_q <= |(out_d ^ out_q);
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: run-length reference model plus directed literal checks and random stimulus.
module tb_debouncer;

  localparam int SC = 4;
`ifdef DEBOUNCER_EDGE_PULSE_EN
  localparam bit EP = 1'b1;
`else
  localparam bit EP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] drise;
  logic [7:0] dfall;
  logic       dchg;

  int total = 0;
  int bad   = 0;

  logic [7:0] mout;
  logic [7:0] mrise;
  logic [7:0] mfall;
  logic       mchg;
  int         run [8];

  debouncer #(.WIDTH(8), .STABLE_CYCLES(SC), .RESET_LEVEL(1'b0)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (din),
    .out     (dout),
    .rise    (drise),
    .fall    (dfall),
    .changed (dchg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // A bit's level flips once it has disagreed with the output for SC edges in a row.
  task automatic model_step(input logic [7:0] v, input bit r);
    logic [7:0] prev;
    if (r) begin
      mout  = 8'h00;
      mrise = 8'h00;
      mfall = 8'h00;
      for (int i = 0; i < 8; i++) run[i] = 0;
    end else begin
      prev = mout;
      for (int i = 0; i < 8; i++) begin
        if (v[i] != mout[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        if (run[i] == SC) begin
          mout[i] = v[i];
          run[i]  = 0;
        end
      end
      mrise = mout & ~prev;
      mfall = ~mout & prev;
    end
    mchg = |(mrise | mfall);
  endtask

  task automatic cycle(input logic [7:0] v, input bit r);
    reset = r;
    din   = v;
    model_step(v, r);
    @(negedge clk);
    chk("out", {24'd0, dout}, {24'd0, mout});
    chk("rise", {24'd0, drise}, EP ? {24'd0, mrise} : 32'd0);
    chk("fall", {24'd0, dfall}, EP ? {24'd0, mfall} : 32'd0);
    chk("changed", {31'd0, dchg}, EP ? {31'd0, mchg} : 32'd0);
    if ((drise & dfall) != 8'h00) chk("rise_and_fall", {24'd0, drise & dfall}, 32'd0);
  endtask

  initial begin
    logic [7:0] cur;
    reset = 1'b1;
    din   = 8'h00;
    for (int i = 0; i < 8; i++) run[i] = 0;
    mout = 8'h00; mrise = 8'h00; mfall = 8'h00; mchg = 1'b0;

    // Reset state
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b1);
    chk("rst_out", {24'd0, dout}, 32'h00);
    chk("rst_chg", {31'd0, dchg}, 32'd0);

    // Quiet input
    for (int k = 0; k < 20; k++) cycle(8'h00, 1'b0);
    chk("quiet_out", {24'd0, dout}, 32'h00);

    // Single bit rises on the 4th sampling edge
    for (int k = 1; k <= 6; k++) begin
      cycle(8'h01, 1'b0);
      if (k == 3) chk("r030_pre", {24'd0, dout}, 32'h00);
      if (k == 4) begin
        chk("r030_out", {24'd0, dout}, 32'h01);
        chk("r030_rise", {24'd0, drise}, EP ? 32'h01 : 32'h00);
        chk("r030_chg", {31'd0, dchg}, EP ? 32'd1 : 32'd0);
        chk("r030_model", {24'd0, mout}, 32'h01);
      end
      if (k == 5) chk("r030_rise_off", {24'd0, drise}, 32'h00);
    end
    for (int k = 0; k < 6; k++) cycle(8'h00, 1'b0);
    chk("r030_back", {24'd0, dout}, 32'h00);

    // Glitch of 3 edges rejected, then 4 edges accepted
    for (int k = 0; k < 3; k++) cycle(8'h08, 1'b0);
    cycle(8'h00, 1'b0);
    chk("r031_glitch", {24'd0, dout}, 32'h00);
    for (int k = 1; k <= 4; k++) begin
      cycle(8'h08, 1'b0);
      if (k == 3) chk("r031_pre", {24'd0, dout}, 32'h00);
    end
    chk("r031_out", {24'd0, dout}, 32'h08);
    chk("r031_rise", {24'd0, drise}, EP ? 32'h08 : 32'h00);
    for (int k = 0; k < 6; k++) cycle(8'h00, 1'b0);

    // All bits together
    cycle(8'h00, 1'b1);
    for (int k = 0; k < 4; k++) cycle(8'hFF, 1'b0);
    chk("r032_out", {24'd0, dout}, 32'hFF);
    chk("r032_rise", {24'd0, drise}, EP ? 32'hFF : 32'h00);
    chk("r032_chg", {31'd0, dchg}, EP ? 32'd1 : 32'd0);
    cycle(8'hFF, 1'b0);
    chk("r032_chg_off", {31'd0, dchg}, 32'd0);
    for (int k = 0; k < 4; k++) cycle(8'h00, 1'b0);
    chk("r032_fall_out", {24'd0, dout}, 32'h00);
    chk("r032_fall", {24'd0, dfall}, EP ? 32'hFF : 32'h00);

    // Reset mid-check discards the pending count
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cycle(8'h20, 1'b0);
      if (k == 3) chk("r033_pre", {24'd0, dout}, 32'h00);
    end
    chk("r033_out", {24'd0, dout}, 32'h20);
    for (int k = 0; k < 6; k++) cycle(8'h00, 1'b0);

    // Bit toggling every cycle never changes out
    for (int k = 0; k < 24; k++) cycle((k % 2 == 0) ? 8'h02 : 8'h00, 1'b0);
    chk("toggle_out", {24'd0, dout}, 32'h00);

    // Random stimulus with runs of varying length and rare resets
    cur = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5, 0) == 0) cur = cur ^ (8'h01 << $urandom_range(7, 0));
      cycle(cur, ($urandom_range(299, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 Parameter WIDTH, default 8, number of independent channels (one per NES controller button).
REQ-002 Parameter STABLE_CYCLES, default 16, consecutive differing samples required to accept a new level; legal range 2..65535.
REQ-003 Parameter RESET_LEVEL, default 0, level loaded into every out bit at reset.
REQ-004 Port clk  input  1  sole clock; all logic on posedge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port in  input  WIDTH  raw levels, already synchronized to clk upstream.
REQ-007 Port out  output  WIDTH  debounced levels, registered.
REQ-008 Port rise  output  WIDTH  one-cycle pulse per bit when out bit goes 0->1, registered.
REQ-009 Port fall  output  WIDTH  one-cycle pulse per bit when out bit goes 1->0, registered.
REQ-010 Port changed  output  1  registered OR of rise and fall, same cycle as the pulses.

Function
REQ-011 Each bit i SHALL have an independent two-state FSM (STABLE, CHECK) and a counter sized $clog2(STABLE_CYCLES) bits.
REQ-012 STABLE, in[i]==out[i]: hold state, counter held at 0.
REQ-013 STABLE, in[i]!=out[i]: go to CHECK, counter <= 1.
REQ-014 CHECK, in[i]==out[i]: return to STABLE, counter <= 0, no output change (glitch rejected).
REQ-015 CHECK, in[i]!=out[i], counter < STABLE_CYCLES-1: counter increments by 1.
REQ-016 CHECK, in[i]!=out[i], counter == STABLE_CYCLES-1: out[i] <= in[i], counter <= 0, go to STABLE.
REQ-017 Latency: out[i] SHALL change on exactly the STABLE_CYCLES-th consecutive rising edge at which in[i]!=out[i]; never earlier, never later.
REQ-018 rise[i]/fall[i] SHALL assert on the same edge out[i] changes and deassert on the next edge; never both high for one bit.
REQ-019 Counter SHALL never wrap; maximum value reached is STABLE_CYCLES-1.
REQ-020 Multiple bits completing on the same edge SHALL all update and pulse together; changed high for one cycle.
REQ-021 A bit toggling back and forth every cycle SHALL never change out.
REQ-022 out is only ever written from the FSM; no combinational path from in to any output.

Reset
REQ-023 While reset is high: out = {WIDTH{RESET_LEVEL}}, rise = 0, fall = 0, changed = 0, all FSMs STABLE, all counters 0.
REQ-024 Reset asserted mid-CHECK SHALL discard the pending count; after release, a differing bit requires the full STABLE_CYCLES again.
REQ-025 First sampling edge is the first posedge clk after reset deasserts.

Configuration
REQ-026 Macro DEBOUNCER_EDGE_PULSE_EN controls edge outputs.
REQ-027 Defined: rise, fall and changed behave per REQ-008..REQ-010, REQ-018, REQ-020.
REQ-028 Undefined: rise, fall, changed tied constant 0; no edge registers synthesized; out behaviour unchanged.

Verification (WIDTH=8, STABLE_CYCLES=4, RESET_LEVEL=0, macro defined unless stated)
REQ-029 Reset released, in=8'h00 for 20 cycles -> out=8'h00, rise/fall/changed never asserted.
REQ-030 in[0] 0->1, held -> out[0]=1 on 4th edge sampling in[0]=1; rise[0] and changed high exactly that one cycle; fall=0.
REQ-031 in[3] high for 3 edges then low -> out[3] stays 0, no pulses; then high for 4 edges -> out[3]=1, rise[3] one cycle.
REQ-032 in=8'hFF simultaneously after reset -> out=8'hFF on 4th edge, rise=8'hFF one cycle, changed one cycle; then in=8'h00 -> fall=8'hFF four edges later.
REQ-033 in[5] high for 2 edges, reset pulsed 1 cycle, in[5] kept high -> out[5]=1 only on 4th edge after reset release.
REQ-034 Macro undefined, rerun REQ-030 -> out[0] timing identical, rise/fall/changed constant 0.
